// File: rtl/e10_phy_reconfig_master_if.sv
// e10_phy_reconfig_master_if: command/response channel plus Avalon-MM reconfig bus.
interface e10_phy_reconfig_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [9:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [31:0] cmd_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        reconfig_read;
  logic        reconfig_write;
  logic [9:0]  reconfig_address;
  logic [31:0] reconfig_writedata;
  logic [31:0] reconfig_readdata;
  logic        reconfig_waitrequest;
  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rsp_ready,
           reconfig_readdata, reconfig_waitrequest,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           reconfig_read, reconfig_write, reconfig_address, reconfig_writedata
  );
  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rsp_ready,
           reconfig_readdata, reconfig_waitrequest,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           reconfig_read, reconfig_write, reconfig_address, reconfig_writedata
  );
endinterface

// File: rtl/e10_phy_reconfig_master.sv
// e10_phy_reconfig_master: read/write/RMW master for the PHY reconfig Avalon-MM slave.
module e10_phy_reconfig_master #(parameter int TIMEOUT_CYCLES = 1024) (
  input logic reconfig_clk,
  input logic reconfig_reset_n,
  e10_phy_reconfig_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;
  state_t      state_q, state_d;
  logic        rmw_q, rmw_d;
  logic [9:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mask_q, mask_d;
  logic [31:0] wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        done, stall_to;
`ifdef E10_RECONFIG_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign stall_to = bus.reconfig_waitrequest && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_comb cnt_d = state_d != state_q ? '0 :
                      (bus.reconfig_waitrequest && (state_q == RD || state_q == WR)) ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge reconfig_clk)
    if (!reconfig_reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign stall_to = 1'b0;
`endif
  assign done = !bus.reconfig_waitrequest || stall_to;
  always_comb begin
    state_d = state_q;
    rmw_d   = rmw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (state_q == IDLE && bus.cmd_valid) begin
      rmw_d   = bus.cmd_op == 2'b10;
      addr_d  = bus.cmd_addr;
      wdata_d = bus.cmd_wdata;
      mask_d  = bus.cmd_mask;
      wr_d    = bus.cmd_wdata;
      rdata_d = '0;
      err_d   = bus.cmd_op == 2'b11;
      state_d = bus.cmd_op == 2'b11 ? RSP : bus.cmd_op == 2'b01 ? WR : RD;
    end else if (state_q == RD && done) begin
      rdata_d = stall_to ? '0 : bus.reconfig_readdata;
      err_d   = stall_to;
      wr_d    = stall_to ? wr_q : (bus.reconfig_readdata & ~mask_q) | (wdata_q & mask_q);
      state_d = (rmw_q && !stall_to) ? WR : RSP;
    end else if (state_q == WR && done) begin
      rdata_d = stall_to ? '0 : rdata_q;
      err_d   = stall_to;
      state_d = RSP;
    end else if (state_q == RSP && bus.rsp_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge reconfig_clk) begin
    if (!reconfig_reset_n) begin
      state_q <= IDLE;
      rmw_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      wr_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rmw_q   <= rmw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  assign bus.cmd_ready          = state_q == IDLE && reconfig_reset_n;
  assign bus.busy               = state_q != IDLE;
  assign bus.rsp_valid          = state_q == RSP;
  assign bus.rsp_rdata          = rdata_q;
  assign bus.rsp_err            = err_q;
  assign bus.reconfig_read      = state_q == RD;
  assign bus.reconfig_write     = state_q == WR;
  assign bus.reconfig_address   = addr_q;
  assign bus.reconfig_writedata = wr_q;
endmodule

// File: tb/tb_e10_phy_reconfig_master.sv
// tb_e10_phy_reconfig_master: scoreboard bench with memory-backed Avalon slave model.
module tb_e10_phy_reconfig_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
`ifdef E10_RECONFIG_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif
  e10_phy_reconfig_master_if bus();
  e10_phy_reconfig_master #(.TIMEOUT_CYCLES(TO)) dut (.reconfig_clk(clk), .reconfig_reset_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    int          rdcyc;
    logic [31:0] wd;
    logic [9:0]  addr;
  } exp_t;
  exp_t q[$];
  exp_t cur;
  int checks = 0, fails = 0;
  logic [31:0] slv_mem [1024];
  logic [31:0] ref_mem [1024];
  int stall_mode = 0, stall_pct = 0, stall_fix = 0, rsp_hold = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    logic [1:0] k, pk;
    int pc;
    logic w;
    pk = 2'b00;
    pc = 0;
    bus.reconfig_waitrequest = 1'b0;
    bus.reconfig_readdata = '0;
    forever begin
      @(posedge clk); #1;
      k = {bus.reconfig_write, bus.reconfig_read};
      if (k != pk) pc = 0;
      pk = k;
      w = stall_mode == 1 ? ($urandom_range(0, 99) < stall_pct) :
          stall_mode == 2 ? (pc < stall_fix) : 1'b0;
      pc++;
      bus.reconfig_waitrequest = w;
      bus.reconfig_readdata = w ? $urandom : slv_mem[bus.reconfig_address];
      if (bus.reconfig_write && !w) slv_mem[bus.reconfig_address] = bus.reconfig_writedata;
    end
  end

  initial begin
    int hc;
    hc = 0;
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.rsp_valid) begin
        bus.rsp_ready = hc >= rsp_hold;
        hc++;
      end else begin
        hc = 0;
        bus.rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  int cyc = 0, t_acc = 0, rd_cyc = 0, nrd = 0, nwr = 0, done = 0;
  logic [31:0] wd_seen, prd;
  logic act = 1'b0, seen = 1'b0, perr;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      act = 1'b0;
      seen = 1'b0;
    end else begin
      chk("cmd_ready_vs_busy", bus.cmd_ready, !bus.busy);
      chk("strobe_exclusive", bus.reconfig_read & bus.reconfig_write, 0);
      if (bus.cmd_valid && bus.cmd_ready) begin
        if (q.size() == 0) begin
          checks++; fails++;
          $display("FAIL accept_without_expectation: got accept expected none");
        end else cur = q.pop_front();
        act = 1'b1; seen = 1'b0; t_acc = cyc; rd_cyc = 0; nrd = 0; nwr = 0; wd_seen = '0;
      end else if (act) begin
        if (bus.reconfig_read) begin
          rd_cyc++;
          if (!bus.reconfig_waitrequest) nrd++;
          chk("read_address", bus.reconfig_address, cur.addr);
        end
        if (bus.reconfig_write) begin
          chk("write_address", bus.reconfig_address, cur.addr);
          if (!bus.reconfig_waitrequest) begin nwr++; wd_seen = bus.reconfig_writedata; end
        end
        if (bus.rsp_valid) begin
          if (!seen) begin
            seen = 1'b1;
            chk("rsp_rdata", bus.rsp_rdata, cur.rdata);
            chk("rsp_err", bus.rsp_err, cur.err);
            chk("read_phases", nrd, cur.nrd);
            chk("write_phases", nwr, cur.nwr);
            if (cur.nwr > 0) chk("writedata", wd_seen, cur.wd);
            if (cur.lat >= 0) chk("latency", cyc - t_acc, cur.lat);
            if (cur.rdcyc >= 0) chk("read_strobe_cycles", rd_cyc, cur.rdcyc);
            prd = bus.rsp_rdata;
            perr = bus.rsp_err;
          end else begin
            chk("rsp_rdata_stable", bus.rsp_rdata, prd);
            chk("rsp_err_stable", bus.rsp_err, perr);
          end
          if (bus.rsp_ready) begin act = 1'b0; done++; end
        end
      end else chk("rsp_valid_idle", bus.rsp_valid, 0);
    end
  end

  task automatic send(input logic [1:0] op, input logic [9:0] a, input logic [31:0] wd,
                      input logic [31:0] m, input int lat, input int rdc, input bit to);
    exp_t e;
    logic [31:0] old;
    int t;
    old = ref_mem[a];
    e.addr = a; e.lat = lat; e.rdcyc = rdc;
    e.err = op == 2'd3 || to;
    e.rdata = (op == 2'd3 || op == 2'd1 || to) ? 32'd0 : old;
    e.nrd = ((op == 2'd0 || op == 2'd2) && !to) ? 1 : 0;
    e.nwr = ((op == 2'd1 || op == 2'd2) && !to) ? 1 : 0;
    e.wd = op == 2'd1 ? wd : op == 2'd2 ? ((old & ~m) | (wd & m)) : 32'd0;
    if (e.nwr > 0) ref_mem[a] = e.wd;
    q.push_back(e);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_wdata = wd; bus.cmd_mask = m;
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.cmd_ready) break;
      t++;
      if (t > 5000) begin
        checks++; fails++;
        $display("FAIL cmd_accept_timeout: got no accept expected accept");
        break;
      end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_wdata = $urandom; bus.cmd_mask = $urandom;
  endtask

  task automatic wait_done(input int d0);
    int t;
    t = 0;
    while (done == d0 && t < 5000) begin @(posedge clk); t++; end
    if (done == d0) begin
      checks++; fails++;
      $display("FAIL response_timeout: got none expected response");
    end
  endtask

  task automatic txn(input logic [1:0] op, input logic [9:0] a, input logic [31:0] wd,
                     input logic [31:0] m, input int lat, input int rdc, input bit to);
    int d0;
    d0 = done;
    send(op, a, wd, m, lat, rdc, to);
    wait_done(d0);
  endtask

  initial begin
    logic [31:0] saved;
    int t;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr = '0; bus.cmd_wdata = '0; bus.cmd_mask = '0;
    for (int i = 0; i < 1024; i++) begin
      slv_mem[i] = $urandom;
      ref_mem[i] = slv_mem[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", bus.cmd_ready, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_err", bus.rsp_err, 0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 0);
    chk("reset_strobes", {bus.reconfig_read, bus.reconfig_write}, 0);
    chk("reset_address", bus.reconfig_address, 0);
    chk("reset_writedata", bus.reconfig_writedata, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("release_cmd_ready", bus.cmd_ready, 1);

    slv_mem[10'h2A0] = 32'hDEADBEEF; ref_mem[10'h2A0] = 32'hDEADBEEF;
    txn(2'd0, 10'h2A0, $urandom, $urandom, 2, 1, 0);
    slv_mem[10'h011] = 32'hFFFF0000; ref_mem[10'h011] = 32'hFFFF0000;
    stall_mode = 2; stall_fix = 3;
    txn(2'd2, 10'h011, 32'h12345678, 32'h000000FF, -1, 4, 0);
    chk("rmw_mem_result", slv_mem[10'h011], 32'hFFFF0078);
    stall_mode = 0; rsp_hold = 5;
    txn(2'd1, 10'h123, 32'hA5A55A5A, $urandom, 2, 0, 0);
    chk("write_mem_result", slv_mem[10'h123], 32'hA5A55A5A);
    rsp_hold = 0;
    txn(2'd3, 10'h044, $urandom, $urandom, 1, 0, 0);
    txn(2'd2, 10'h005, $urandom, $urandom, 3, 1, 0);
    txn(2'd2, 10'h006, $urandom, 32'h0, 3, 1, 0);

    stall_mode = 1; stall_pct = 25;
    for (int i = 0; i < 200; i++) begin
      rsp_hold = $urandom_range(0, 3);
      txn(2'($urandom_range(0, 3)), 10'($urandom_range(0, 15)), $urandom, $urandom, -1, -1, 0);
    end
    rsp_hold = 0;
`ifdef E10_RECONFIG_TIMEOUT_EN
    stall_mode = 2; stall_fix = 1 << 30;
    txn(2'd2, 10'h007, $urandom, $urandom, -1, 8, 1);
    txn(2'd1, 10'h008, $urandom, $urandom, -1, 0, 1);
    stall_mode = 0;
    txn(2'd0, 10'h007, $urandom, $urandom, 2, 1, 0);
`endif

    stall_mode = 2; stall_fix = 1 << 30;
    saved = ref_mem[10'h00C];
    send(2'd1, 10'h00C, 32'hCAFEF00D, $urandom, -1, -1, 0);
    ref_mem[10'h00C] = saved;
    t = 0;
    while (!bus.reconfig_write && t < 100) begin @(negedge clk); t++; end
    chk("write_strobe_seen", bus.reconfig_write, 1);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("reset_mid_write_strobe", bus.reconfig_write, 0);
    chk("reset_mid_write_rsp", bus.rsp_valid, 0);
    stall_mode = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_cmd_ready", bus.cmd_ready, 1);
    chk("post_reset_busy", bus.busy, 0);
    txn(2'd0, 10'h00C, $urandom, $urandom, 2, 1, 0);

    for (int i = 0; i < 16; i++) chk("final_mem", slv_mem[i], ref_mem[i]);
    chk("final_mem_2a0", slv_mem[10'h2A0], ref_mem[10'h2A0]);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/e10_phy_reconfig_master.md
E10_PHY_RECONFIG_MASTER -- requirements
Module: e10_phy_reconfig_master

Interface
REQ-001 TIMEOUT_CYCLES, 1024, waitrequest-high cycles per bus phase before abort (only with E10_RECONFIG_TIMEOUT_EN).
REQ-002 reconfig_clk  in  1  single clock for all logic.
REQ-003 reconfig_reset_n  in  1  reset, synchronous to reconfig_clk, active-low.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-006 cmd_op  in  2  00 read, 01 write, 10 read-modify-write, 11 reserved.
REQ-007 cmd_addr  in  10  transceiver register word address.
REQ-008 cmd_wdata  in  32  write data, or RMW field value.
REQ-009 cmd_mask  in  32  RMW bit mask; 1 = take bit from cmd_wdata.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
REQ-012 rsp_rdata  out  32  read data; for RMW, the pre-modify value; 0 for write.
REQ-013 rsp_err  out  1  reserved op or timeout.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 reconfig_read  out  1  Avalon-MM read strobe to PHY reconfig slave.
REQ-016 reconfig_write  out  1  Avalon-MM write strobe.
REQ-017 reconfig_address  out  10  Avalon-MM address.
REQ-018 reconfig_writedata  out  32  Avalon-MM write data.
REQ-019 reconfig_readdata  in  32  slave read data.
REQ-020 reconfig_waitrequest  in  1  slave stall.

Function
REQ-021 States IDLE, RD, WR, RSP; IDLE is the only state with cmd_ready=1.
REQ-022 On accept in cycle N, latch op/addr/wdata/mask; op 00 or 10 -> RD, op 01 -> WR, op 11 -> RSP with rsp_err=1 and no bus cycle; strobe is first visible in N+1.
REQ-023 RD: reconfig_read=1 and reconfig_address=latched addr held stable until the cycle with reconfig_waitrequest=0; reconfig_readdata is sampled in that cycle.
REQ-024 Read complete, op 00 -> RSP next cycle with rsp_rdata=sampled data and rsp_err=0.
REQ-025 Read complete, op 10 -> WR next cycle with writedata=(rdata & ~mask) | (wdata & mask) and rsp_rdata=rdata.
REQ-026 WR: reconfig_write=1 with address and writedata held stable until reconfig_waitrequest=0; go to RSP next cycle with rsp_err=0.
REQ-027 Op 01 reports rsp_rdata=0.
REQ-028 reconfig_read and reconfig_write are never high in the same cycle; both are 0 outside RD/WR.
REQ-029 RSP: rsp_valid=1 with rsp_rdata and rsp_err held until rsp_ready=1; then IDLE next cycle.
REQ-030 A new command is accepted no earlier than the cycle after the response handshake; there is no command/response overlap.
REQ-031 Minimum latency with waitrequest=0 throughout: read = rsp_valid at N+2; RMW = rsp_valid at N+3.
REQ-032 mask=0 RMW still issues the write, with writedata = rdata.

Reset
REQ-033 With reconfig_reset_n=0 at a clock edge: state=IDLE; reconfig_read, reconfig_write, rsp_valid, rsp_err and busy=0; rsp_rdata, reconfig_address and reconfig_writedata=0; cmd_ready=0 during reset and 1 in the first cycle after release.
REQ-034 Reset during RD/WR drops the strobe at that edge; the in-flight command is discarded with no response.

Configuration
REQ-035 E10_RECONFIG_TIMEOUT_EN defined: a per-phase counter clears on entering RD/WR and increments each cycle with waitrequest=1; when the count reaches TIMEOUT_CYCLES, the strobe drops next cycle and the block goes to RSP with rsp_err=1 and rsp_rdata=0; an RMW that times out in RD issues no write.
REQ-036 E10_RECONFIG_TIMEOUT_EN undefined: no counter logic; RD/WR wait indefinitely; rsp_err is set only for op 11.

Verification
REQ-037 Read addr 0x2A0, waitrequest=0, readdata=0xDEADBEEF -> read high for 1 cycle; rsp_valid at N+2 with rdata 0xDEADBEEF, err=0.
REQ-038 RMW addr 0x011, rdata=0xFFFF0000, mask=0x000000FF, wdata=0x12345678, waitrequest high for 3 cycles in each phase -> writedata 0xFFFF0078; rsp_rdata 0xFFFF0000.
REQ-039 Write with rsp_ready held low 5 cycles -> rsp_valid, rsp_rdata=0 and err=0 stable for all 5 cycles; cmd_ready=0 until the cycle after the handshake.
REQ-040 Op 11 -> no read or write strobe; rsp_valid at N+1 with err=1.
REQ-041 With E10_RECONFIG_TIMEOUT_EN, TIMEOUT_CYCLES=8, waitrequest stuck at 1 on RMW -> read drops after 8 stalled cycles; err=1; write never asserted.
REQ-042 reconfig_reset_n=0 mid-WR -> write=0 at that edge; no rsp_valid; first cycle after release is IDLE with cmd_ready=1.
